// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle special cases for divide-by-zero and overflow.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  input  logic [TAG_W-1:0] i_rd_in,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_stall_req,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_rd_out
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opb;
  logic [2:0]          r_op;
  logic [TAG_W-1:0]    r_tag;
  logic                r_neg_q, r_neg_r;
  logic [XLEN-1:0]     r_result;
  logic [TAG_W-1:0]    r_rd_out;

  logic                w_accept, w_is_div, w_last;
  logic                w_sgn_a_en, w_sgn_b_en, w_sign_a, w_sign_b;
  logic [XLEN-1:0]     w_mag_a, w_mag_b;
  logic                w_div0, w_ovf, w_special;
  logic [XLEN-1:0]     w_special_res;
  logic [XLEN:0]       w_add, w_shift, w_diff;
  logic                w_ge;
  logic [2*XLEN-1:0]   w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [XLEN-1:0]     w_q, w_r, w_final;

  assign w_accept   = i_start & (r_state != S_BUSY) & ~i_flush;
  assign w_is_div   = i_op[2];
  assign w_sgn_a_en = (i_op == 3'b001) | (i_op == 3'b010) | (i_op == 3'b100) | (i_op == 3'b110);
  assign w_sgn_b_en = (i_op == 3'b001) | (i_op == 3'b100) | (i_op == 3'b110);
  assign w_sign_a   = w_sgn_a_en & i_a[XLEN-1];
  assign w_sign_b   = w_sgn_b_en & i_b[XLEN-1];
  assign w_mag_a    = w_sign_a ? -i_a : i_a;
  assign w_mag_b    = w_sign_b ? -i_b : i_b;

  assign w_div0    = w_is_div & (i_b == '0);
  assign w_ovf     = ((i_op == 3'b100) | (i_op == 3'b110)) &
                     (i_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_b == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    if (w_div0) w_special_res = i_op[1] ? i_a : '1;
    else        w_special_res = i_op[1] ? '0  : i_a;
  end

  // Multiply keeps the multiplier in the low half and shifts the product in from the top.
  assign w_add     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_nxt = {w_add, r_acc[XLEN-1:1]};

  // Divide keeps the partial remainder high and dividend/quotient low, shifting left.
  assign w_shift   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ge      = (w_shift >= {1'b0, r_opb});
  assign w_diff    = w_shift - {1'b0, r_opb};
  assign w_div_nxt = {(w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

  assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;
  assign w_last    = (r_cnt == CW'(XLEN-1));

  assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_q    = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_r    = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    if (r_op[2])               w_final = r_op[1] ? w_r : w_q;
    else if (r_op == 3'b000)   w_final = w_prod[XLEN-1:0];
    else                       w_final = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) w_state_nxt = w_special ? S_DONE : S_BUSY;
          else         w_state_nxt = S_IDLE;
        end
        S_BUSY:  if (w_last) w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy      = (r_state == S_BUSY);
    o_valid     = (r_state == S_DONE);
    o_stall_req = (i_start & (r_state != S_BUSY) & ~i_flush) | (r_state == S_BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_op     <= '0;
      r_tag    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (w_accept) begin
      r_op    <= i_op;
      r_tag   <= i_rd_in;
      r_cnt   <= '0;
      r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
      r_opb   <= w_is_div ? w_mag_b : w_mag_a;
      r_neg_q <= w_sign_a ^ w_sign_b;
      r_neg_r <= w_sign_a;
      if (w_special) begin
        r_result <= w_special_res;
        r_rd_out <= i_rd_in;
      end
    end else if ((r_state == S_BUSY) && !i_flush) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_result <= w_final;
        r_rd_out <= r_tag;
      end
    end
  end

  assign o_result = r_result;
  assign o_rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle scoreboard of
// valid/busy/stall_req/result/rd_out, and a 16-bit instance latency check.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, stall_req, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  logic        start16 = 1'b0, flush16 = 1'b0;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [4:0]  rd16 = '0;
  logic        busy16, stall16, valid16;
  logic [15:0] result16;
  logic [4:0]  rd_out16;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_rd_in(rd_in), .i_flush(flush), .o_busy(busy), .o_stall_req(stall_req),
    .o_valid(valid), .o_result(result), .o_rd_out(rd_out));

  muldiv_unit #(.XLEN(16), .TAG_W(5)) dut16 (
    .clk(clk), .rst(rst), .i_start(start16), .i_op(op16), .i_a(a16), .i_b(b16),
    .i_rd_in(rd16), .i_flush(flush16), .o_busy(busy16), .o_stall_req(stall16),
    .o_valid(valid16), .o_result(result16), .o_rd_out(rd_out16));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  int          q_cyc[$];
  logic [31:0] q_res[$];
  logic [4:0]  q_tag[$];
  bit          bmap[int];
  logic [31:0] last_res = '0;
  logic [4:0]  last_tag = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                        input logic [31:0] y, input int w);
    longint      mask = (longint'(1) << w) - 1;
    longint      ua   = longint'(x) & mask;
    longint      ub   = longint'(y) & mask;
    longint      half = longint'(1) << (w - 1);
    longint      sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
    longint      sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
    bit          ovf  = (sa == -half) && (sb == -1);
    longint      r;
    logic [63:0] pu;
    case (f)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: begin pu = $unsigned(ua) * $unsigned(ub); r = longint'(pu >> w); end
      3'd4: r = (ub == 0) ? mask : (ovf ? ua : sa / sb);
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: r = (ub == 0) ? ua : (ovf ? 0 : sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    return 32'(r & mask);
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && ((y == 0) || (((f == 3'd4) || (f == 3'd6)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expectation for an op accepted in the current cycle.
  task automatic expect_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                           input logic [4:0] tag);
    bit sp = is_special(f, x, y);
    q_cyc.push_back(cyc + (sp ? 1 : 33));
    q_res.push_back(model(f, x, y, 32));
    q_tag.push_back(tag);
    if (!sp) for (int i = 1; i <= 32; i++) bmap[cyc + i] = 1'b1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] tag);
    op = f; a = x; b = y; rd_in = tag; start = 1'b1;
    expect_op(f, x, y, tag);
    step();
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    bit ev, eb;
    ev = (q_cyc.size() > 0) && (q_cyc[0] == cyc);
    eb = bmap.exists(cyc);
    chk("valid", valid, ev);
    chk("busy", busy, eb);
    chk("stall_req", stall_req, eb | (start & ~flush & ~eb));
    if (ev) begin
      chk("result", result, q_res[0]);
      chk("rd_out", rd_out, q_tag[0]);
      last_res = q_res.pop_front();
      last_tag = q_tag.pop_front();
      void'(q_cyc.pop_front());
    end else begin
      chk("result_hold", result, last_res);
      chk("rd_out_hold", rd_out, last_tag);
    end
  end

  typedef struct {logic [2:0] f; logic [31:0] x; logic [31:0] y;} vec_t;
  vec_t vecs [16] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD},
    '{3'd1, 32'h8000_0000,  32'h8000_0000},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF},
    '{3'd2, 32'hFFFF_FFFF,  32'd2},
    '{3'd1, 32'hFFFF_FFFE,  32'd3},
    '{3'd4, 32'hFFFF_FFF9,  32'd2},
    '{3'd6, 32'hFFFF_FFF9,  32'd2},
    '{3'd4, 32'd7,          32'hFFFF_FFFE},
    '{3'd5, 32'd100,        32'd7},
    '{3'd7, 32'd100,        32'd7},
    '{3'd5, 32'd5,          32'd0},
    '{3'd6, 32'd5,          32'd0},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9,  32'd0},
    '{3'd7, 32'hFFFF_FFF9,  32'd0}
  };

  initial begin
    int c0, lat16, nvalid16, nbusy16;
    logic [15:0] res16;
    logic [4:0]  tag16;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_result", result, 0);
    chk("rst_rd_out", rd_out, 0);

    // Hand-computed pins on the reference model.
    chk("pin_mul",    model(3'd0, 32'd7, 32'hFFFF_FFFD, 32), 32'hFFFF_FFEB);
    chk("pin_mulh",   model(3'd1, 32'h8000_0000, 32'h8000_0000, 32), 32'h4000_0000);
    chk("pin_mulhu",  model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'hFFFF_FFFE);
    chk("pin_mulhsu", model(3'd2, 32'hFFFF_FFFF, 32'd2, 32), 32'hFFFF_FFFF);
    chk("pin_div",    model(3'd4, 32'hFFFF_FFF9, 32'd2, 32), 32'hFFFF_FFFD);
    chk("pin_rem",    model(3'd6, 32'hFFFF_FFF9, 32'd2, 32), 32'hFFFF_FFFF);
    chk("pin_divu",   model(3'd5, 32'd100, 32'd7, 32), 32'd14);
    chk("pin_remu",   model(3'd7, 32'd100, 32'd7, 32), 32'd2);
    chk("pin_divu0",  model(3'd5, 32'd5, 32'd0, 32), 32'hFFFF_FFFF);
    chk("pin_rem0",   model(3'd6, 32'd5, 32'd0, 32), 32'd5);
    chk("pin_divovf", model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32), 32'h8000_0000);
    chk("pin_removf", model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32), 32'd0);
    chk("pin_mul16",  model(3'd0, 32'd7, 32'h0000_FFFD, 16), 32'h0000_FFEB);

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].x, vecs[i].y, 5'(i + 1));
      repeat (is_special(vecs[i].f, vecs[i].x, vecs[i].y) ? 1 : 33) step();
    end

    // Flush in cycle 10 of a DIV.
    issue(3'd4, 32'd1000, 32'd3, 5'd20);
    repeat (9) step();
    flush = 1'b1;
    void'(q_cyc.pop_back()); void'(q_res.pop_back()); void'(q_tag.pop_back());
    for (int i = cyc + 1; i <= cyc + 40; i++) if (bmap.exists(i)) bmap.delete(i);
    step();
    flush = 1'b0;
    repeat (40) step();

    // Flush together with start drops the request.
    op = 3'd0; a = 32'd5; b = 32'd5; rd_in = 5'd21; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    repeat (40) step();

    // Start held into DONE: back-to-back ops; second valid at +66.
    c0 = cyc;
    op = 3'd0; a = 32'd12; b = 32'd11; rd_in = 5'd22; start = 1'b1;
    expect_op(3'd0, 32'd12, 32'd11, 5'd22);
    step();
    op = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd23;
    repeat (32) step();
    chk("b2b_accept_cycle", cyc - c0, 33);
    expect_op(3'd5, 32'd100, 32'd7, 5'd23);
    chk("b2b_second_valid_cycle", q_cyc[q_cyc.size()-1] - c0, 66);
    step();
    start = 1'b0;
    repeat (33) step();

    // Start pulses during BUSY are ignored.
    issue(3'd5, 32'd200, 32'd9, 5'd24);
    repeat (4) step();
    op = 3'd0; a = 32'd3; b = 32'd3; rd_in = 5'd25; start = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (13) step();

    // Async reset in cycle 15 of a MUL.
    issue(3'd0, 32'd123, 32'd456, 5'd26);
    repeat (14) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid, 0);
    chk("arst_result", result, 0);
    chk("arst_rd_out", rd_out, 0);
    chk("arst_stall", stall_req, 0);
    q_cyc.delete(); q_res.delete(); q_tag.delete(); bmap.delete();
    last_res = '0; last_tag = '0;
    step();
    rst = 1'b0;
    step();
    issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd27);
    repeat (34) step();

    // 16-bit instance: valid exactly once, 17 cycles after start.
    a16 = 16'd7; b16 = 16'hFFFD; op16 = 3'd0; rd16 = 5'd9; start16 = 1'b1;
    step();
    start16 = 1'b0;
    lat16 = -1; nvalid16 = 0; nbusy16 = 0; res16 = '0; tag16 = '0;
    for (int k = 1; k <= 40; k++) begin
      if (busy16) nbusy16++;
      if (valid16) begin
        nvalid16++;
        if (lat16 < 0) begin lat16 = k; res16 = result16; tag16 = rd_out16; end
      end
      step();
    end
    chk("x16_latency", lat16, 17);
    chk("x16_result", res16, 16'hFFEB);
    chk("x16_rd_out", tag16, 5'd9);
    chk("x16_valid_count", nvalid16, 1);
    chk("x16_busy_cycles", nbusy16, 16);

    chk("pending_expectations", q_cyc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
